// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
// Sequencer for the 16-lane MAC datapath. For each output it reads one data
// vector and one weight row, chunk by chunk, from the data and weight buffers.
// It drives the MAC valid input and accumulates the per-chunk MAC sums into
// one wide signed result per output. Each result is tagged with its index.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   start                   one-cycle start pulse; only honoured in IDLE
//   cfg_nchunk, cfg_nout    chunks per output, number of outputs
//   cfg_wbase, cfg_dbase    weight / data buffer base addresses
//   busy, done              job in progress / one-cycle end-of-job pulse
//   w_rd_en, w_rd_addr      weight buffer read port
//   d_rd_en, d_rd_addr      data buffer read port
//   mac_vld_i               MAC input valid, aligned with buffer read data
//   mac_acc_o, mac_vld_o    per-chunk signed sum from the MAC and its valid
//   res_o, res_vld_o        final accumulated result and its one-cycle strobe
//   res_idx_o               output index of res_o
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_nchunk,
    input  logic [CNT_W-1:0]  cfg_nout,
    input  logic [ADDR_W-1:0] cfg_wbase,
    input  logic [ADDR_W-1:0] cfg_dbase,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              d_rd_en,
    output logic [ADDR_W-1:0] d_rd_addr,
    output logic              mac_vld_i,
    input  logic [19:0]       mac_acc_o,
    input  logic              mac_vld_o,
    output logic [ACC_W-1:0]  res_o,
    output logic              res_vld_o,
    output logic [CNT_W-1:0]  res_idx_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0]  ACC_ZERO  = {ACC_W{1'b0}};

    // Sign-extend a 20-bit MAC chunk sum to the accumulator width.
    function automatic logic [ACC_W-1:0] sext20(input logic [19:0] v);
        return {{(ACC_W-20){v[19]}}, v};
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   nchunk_r;
    logic [CNT_W-1:0]   nout_r;
    logic [ADDR_W-1:0]  dbase_r;
    logic [CNT_W-1:0]   chunk_r;
    logic [CNT_W-1:0]   out_r;
    logic               busy_r;
    logic               done_r;
    logic               rd_en_r;
    logic [ADDR_W-1:0]  w_addr_r;
    logic [ADDR_W-1:0]  d_addr_r;
    logic               mac_vld_i_r;

    logic [CNT_W-1:0]   rx_chunk_r;
    logic [CNT_W-1:0]   rx_out_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   res_r;
    logic               res_vld_r;
    logic [CNT_W-1:0]   res_idx_r;

    logic               start_acc_s;
    logic [ACC_W-1:0]   acc_base_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic               rx_last_s;
    logic [CNT_W-1:0]   rx_out_nxt_s;

    // Receive-side arithmetic and the result count including a strobe being produced now.
    always_comb begin
        start_acc_s = (state_r == ST_IDLE) && start;
        if (rx_chunk_r == CNT_ZERO) begin
            acc_base_s = ACC_ZERO;            // first chunk of an output loads instead of adding
        end else begin
            acc_base_s = acc_r;
        end
        acc_sum_s = acc_base_s + sext20(mac_acc_o);
        rx_last_s = mac_vld_o && (rx_chunk_r == (nchunk_r - CNT_ONE));
        if (rx_last_s) begin
            rx_out_nxt_s = rx_out_r + CNT_ONE;
        end else begin
            rx_out_nxt_s = rx_out_r;
        end
    end

    // Job FSM: config latch, read issue with running addresses, and done/busy handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            nchunk_r    <= CNT_ZERO;
            nout_r      <= CNT_ZERO;
            dbase_r     <= ADDR_ZERO;
            chunk_r     <= CNT_ZERO;
            out_r       <= CNT_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            w_addr_r    <= ADDR_ZERO;
            d_addr_r    <= ADDR_ZERO;
            mac_vld_i_r <= 1'b0;
        end else begin
            // Buffers have one cycle of read latency, so the MAC valid trails the read by one.
            mac_vld_i_r <= rd_en_r;
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r   <= 1'b1;
                        nchunk_r <= cfg_nchunk;
                        nout_r   <= cfg_nout;
                        dbase_r  <= cfg_dbase;
                        chunk_r  <= CNT_ZERO;
                        out_r    <= CNT_ZERO;
                        if ((cfg_nchunk == CNT_ZERO) || (cfg_nout == CNT_ZERO)) begin
                            state_r <= ST_FIN;
                        end else begin
                            // First read is presented straight away so reads run without bubbles.
                            state_r  <= ST_ISSUE;
                            rd_en_r  <= 1'b1;
                            w_addr_r <= cfg_wbase;
                            d_addr_r <= cfg_dbase;
                        end
                    end
                end
                ST_ISSUE: begin
                    // The weight address is a running counter: wbase + out*nchunk + chunk.
                    w_addr_r <= w_addr_r + ADDR_ONE;
                    if (chunk_r == (nchunk_r - CNT_ONE)) begin
                        chunk_r <= CNT_ZERO;
                        if (out_r == (nout_r - CNT_ONE)) begin
                            rd_en_r <= 1'b0;
                            state_r <= ST_DRAIN;
                        end else begin
                            out_r    <= out_r + CNT_ONE;
                            d_addr_r <= dbase_r;
                        end
                    end else begin
                        chunk_r  <= chunk_r + CNT_ONE;
                        d_addr_r <= d_addr_r + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (rx_out_nxt_s == nout_r) begin
                        state_r <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Receive side: counts MAC valids only, so it is independent of MAC latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_chunk_r <= CNT_ZERO;
            rx_out_r   <= CNT_ZERO;
            acc_r      <= ACC_ZERO;
            res_r      <= ACC_ZERO;
            res_vld_r  <= 1'b0;
            res_idx_r  <= CNT_ZERO;
        end else begin
            res_vld_r <= 1'b0;
            if (start_acc_s) begin
                rx_chunk_r <= CNT_ZERO;
                rx_out_r   <= CNT_ZERO;
                acc_r      <= ACC_ZERO;
            end else if (mac_vld_o) begin
                acc_r <= acc_sum_s;
                if (rx_last_s) begin
                    rx_chunk_r <= CNT_ZERO;
                    rx_out_r   <= rx_out_nxt_s;
                    res_r      <= acc_sum_s;
                    res_vld_r  <= 1'b1;
                    res_idx_r  <= rx_out_r;
                end else begin
                    rx_chunk_r <= rx_chunk_r + CNT_ONE;
                end
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign w_rd_en   = rd_en_r;
    assign d_rd_en   = rd_en_r;
    assign w_rd_addr = w_addr_r;
    assign d_rd_addr = d_addr_r;
    assign mac_vld_i = mac_vld_i_r;
    assign res_o     = res_r;
    assign res_vld_o = res_vld_r;
    assign res_idx_o = res_idx_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  cfg_nchunk = 10'd0;
    logic [9:0]  cfg_nout = 10'd0;
    logic [9:0]  cfg_wbase = 10'd0;
    logic [9:0]  cfg_dbase = 10'd0;
    logic        busy, done, w_rd_en, d_rd_en, mac_vld_i, mac_vld_o, res_vld_o;
    logic [9:0]  w_rd_addr, d_rd_addr, res_idx_o;
    logic [19:0] mac_acc_o;
    logic [31:0] res_o;

    mac_seq_ctrl #(.ADDR_W(10), .CNT_W(10), .ACC_W(32)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_nchunk(cfg_nchunk), .cfg_nout(cfg_nout),
        .cfg_wbase(cfg_wbase), .cfg_dbase(cfg_dbase),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr),
        .mac_vld_i(mac_vld_i), .mac_acc_o(mac_acc_o), .mac_vld_o(mac_vld_o),
        .res_o(res_o), .res_vld_o(res_vld_o), .res_idx_o(res_idx_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard queues
    logic [9:0]  exp_w_q[$];
    logic [9:0]  exp_d_q[$];
    logic [31:0] exp_res_q[$];
    logic [9:0]  exp_idx_q[$];
    int          ret_q[$];

    // monitor statistics
    int rd_cnt = 0, res_cnt = 0, done_cnt = 0, mvi_cnt = 0;
    int last_res_cyc = 0, done_cyc = 0, first_rd_cyc = -1, last_rd_cyc = 0;
    logic prev_w = 1'b0;
    logic prev_mvo = 1'b0;

    // MAC model: fixed latency, returns values from ret_q in order
    int          mac_lat = 7;
    logic [15:0] vld_pipe;
    logic [19:0] val_pipe [0:15];
    assign mac_vld_o = vld_pipe[mac_lat-1];
    assign mac_acc_o = val_pipe[mac_lat-1];

    always @(posedge clk or negedge rstn) begin
        int v;
        if (!rstn) begin
            vld_pipe <= 16'd0;
            for (int i = 0; i < 16; i++) val_pipe[i] <= 20'd0;
        end else begin
            vld_pipe <= {vld_pipe[14:0], mac_vld_i};
            for (int i = 15; i > 0; i--) val_pipe[i] <= val_pipe[i-1];
            v = 0;
            if (mac_vld_i && ret_q.size() > 0) v = ret_q.pop_front();
            val_pipe[0] <= v[19:0];
        end
    end

    // Monitor: read addresses, mac_vld_i alignment and results against the scoreboard
    always @(negedge clk) begin
        logic [9:0]  ew, ed, ei;
        logic [31:0] er;
        if (rstn) begin
            n_cmp++;
            if (mac_vld_i !== prev_w) begin
                n_err++; $display("FAIL mac_vld_i_align: got %b expected %b", mac_vld_i, prev_w);
            end
            n_cmp++;
            if (d_rd_en !== w_rd_en) begin
                n_err++; $display("FAIL rd_en_pair: d_rd_en %b expected %b", d_rd_en, w_rd_en);
            end
            if (mac_vld_i) mvi_cnt++;
            if (w_rd_en) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                n_cmp++;
                if (exp_w_q.size() == 0) begin
                    n_err++; $display("FAIL unexpected_read: w_rd_addr %h with nothing expected", w_rd_addr);
                end else begin
                    ew = exp_w_q.pop_front();
                    ed = exp_d_q.pop_front();
                    if (w_rd_addr !== ew || d_rd_addr !== ed) begin
                        n_err++;
                        $display("FAIL rd_addr: got w=%h d=%h expected w=%h d=%h", w_rd_addr, d_rd_addr, ew, ed);
                    end
                end
            end
            if (res_vld_o) begin
                res_cnt++;
                last_res_cyc = cyc;
                n_cmp++;
                if (exp_res_q.size() == 0) begin
                    n_err++; $display("FAIL unexpected_result: res_o %h idx %0d", res_o, res_idx_o);
                end else begin
                    er = exp_res_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    if (res_o !== er || res_idx_o !== ei) begin
                        n_err++;
                        $display("FAIL result: got %h idx %0d expected %h idx %0d", res_o, res_idx_o, er, ei);
                    end
                end
                n_cmp++;
                if (prev_mvo !== 1'b1) begin
                    n_err++; $display("FAIL result_timing: mac_vld_o one cycle earlier was %b expected 1", prev_mvo);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_w   = w_rd_en;
        prev_mvo = mac_vld_o;
    end

    // Stimulus: fill scoreboard from the job description, then pulse start
    task automatic start_job(input int nch, input int nout, input logic [9:0] wb, input logic [9:0] db);
        int s;
        if (nch > 0 && nout > 0) begin
            for (int o = 0; o < nout; o++) begin
                s = 0;
                for (int c = 0; c < nch; c++) begin
                    exp_w_q.push_back(10'(int'(wb) + o*nch + c));
                    exp_d_q.push_back(10'(int'(db) + c));
                    s += ret_q[o*nch + c];
                end
                exp_res_q.push_back(32'(s));
                exp_idx_q.push_back(10'(o));
            end
        end
        first_rd_cyc = -1;
        @(negedge clk);
        cfg_nchunk = 10'(nch);
        cfg_nout   = 10'(nout);
        cfg_wbase  = wb;
        cfg_dbase  = db;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Bounded wait for done; cycles counted from the negedge where start was raised
    task automatic wait_done(output int cy, output bit to);
        cy = 1;
        to = 1'b0;
        while (done !== 1'b1) begin
            if (cy >= 300) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cy++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, w_rd_en, w_rd_addr, d_rd_en, d_rd_addr, mac_vld_i, res_o, res_vld_o, res_idx_o} !== '0) begin
            n_err++; $display("FAIL reset_outputs: busy=%b done=%b w_en=%b res=%h", busy, done, w_rd_en, res_o);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cy, r0, d0, m0, rd0;
        bit to;
        mac_lat = 7;
        ret_q = '{1, 2, 3, 4, -5, 6, -7, 8};
        r0 = res_cnt; d0 = done_cnt; m0 = mvi_cnt; rd0 = rd_cnt;
        start_job(4, 2, 10'h010, 10'h040);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done(cy, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL basic_timeout: done=%b expected 1", done); end
        @(negedge clk);
        n_cmp++;
        if (rd_cnt - rd0 !== 8 || last_rd_cyc - first_rd_cyc !== 7) begin
            n_err++; $display("FAIL basic_reads: got %0d reads over span %0d expected 8 over 7", rd_cnt - rd0, last_rd_cyc - first_rd_cyc);
        end
        n_cmp++;
        if (mvi_cnt - m0 !== 8) begin n_err++; $display("FAIL basic_mac_vld_i: got %0d expected 8", mvi_cnt - m0); end
        n_cmp++;
        if (res_cnt - r0 !== 2 || done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL basic_counts: got res %0d done %0d expected 2 1", res_cnt - r0, done_cnt - d0);
        end
        n_cmp++;
        if (!(done_cyc > last_res_cyc)) begin
            n_err++; $display("FAIL basic_done_order: done cycle %0d expected after result cycle %0d", done_cyc, last_res_cyc);
        end
        n_cmp++;
        if (exp_w_q.size() + exp_res_q.size() !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_leftover: got %0d pending busy %b expected 0 0", exp_w_q.size() + exp_res_q.size(), busy);
        end
    endtask

    task automatic test_nchunk1();
        int cy, r0;
        bit to;
        ret_q = '{-524288, 524287, 0};
        r0 = res_cnt;
        start_job(1, 3, 10'h020, 10'h030);
        wait_done(cy, to);
        @(negedge clk);
        n_cmp++;
        if (to || res_cnt - r0 !== 3 || exp_res_q.size() !== 0) begin
            n_err++; $display("FAIL nchunk1_results: got %0d timeout %b expected 3 0", res_cnt - r0, to);
        end
    endtask

    task automatic test_zero();
        int cy, r0, d0, rd0;
        bit to;
        for (int k = 0; k < 2; k++) begin
            r0 = res_cnt; d0 = done_cnt; rd0 = rd_cnt;
            if (k == 0) start_job(0, 5, 10'h011, 10'h022);
            else        start_job(3, 0, 10'h011, 10'h022);
            wait_done(cy, to);
            n_cmp++;
            if (to || cy !== 2) begin n_err++; $display("FAIL zero_done_latency[%0d]: got %0d expected 2", k, cy); end
            @(negedge clk);
            n_cmp++;
            if (rd_cnt - rd0 !== 0 || res_cnt - r0 !== 0 || done_cnt - d0 !== 1) begin
                n_err++; $display("FAIL zero_activity[%0d]: got reads %0d res %0d done %0d expected 0 0 1", k, rd_cnt - rd0, res_cnt - r0, done_cnt - d0);
            end
        end
    endtask

    task automatic test_wrap();
        int cy, rd0;
        bit to;
        ret_q = '{100, -200, 300, -400};
        rd0 = rd_cnt;
        start_job(4, 1, 10'h3FE, 10'h3FD);
        wait_done(cy, to);
        @(negedge clk);
        n_cmp++;
        if (to || rd_cnt - rd0 !== 4 || exp_res_q.size() !== 0) begin
            n_err++; $display("FAIL wrap_job: got reads %0d timeout %b expected 4 0", rd_cnt - rd0, to);
        end
    endtask

    task automatic test_busy_start();
        int cy, r0, rd0, d0;
        bit to;
        ret_q = '{7, 8, 9, 10};
        r0 = res_cnt; rd0 = rd_cnt; d0 = done_cnt;
        start_job(2, 2, 10'h100, 10'h200);
        cfg_nchunk = 10'd3; cfg_nout = 10'd1; cfg_wbase = 10'h2AA; cfg_dbase = 10'h155;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cy, to);
        @(negedge clk);
        n_cmp++;
        if (to || rd_cnt - rd0 !== 4 || res_cnt - r0 !== 2 || done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL busy_start: got reads %0d res %0d done %0d expected 4 2 1", rd_cnt - rd0, res_cnt - r0, done_cnt - d0);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rd_cnt - rd0 !== 4) begin
            n_err++; $display("FAIL busy_start_restart: got busy %b reads %0d expected 0 4", busy, rd_cnt - rd0);
        end
    endtask

    task automatic test_reset_mid();
        int cy, r0, d0;
        bit to;
        ret_q = '{11, 12, 13, 14, 15, 16, 17, 18};
        start_job(4, 2, 10'h000, 10'h000);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, w_rd_en, w_rd_addr, d_rd_en, d_rd_addr, mac_vld_i, res_o, res_vld_o, res_idx_o} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: busy=%b w_en=%b w_addr=%h expected all 0", busy, w_rd_en, w_rd_addr);
        end
        exp_w_q.delete(); exp_d_q.delete(); exp_res_q.delete(); exp_idx_q.delete(); ret_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midreset_no_done: got done %0d busy %b expected 0 0", done_cnt - d0, busy);
        end
        ret_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        r0 = res_cnt; d0 = done_cnt;
        start_job(4, 2, 10'h000, 10'h000);
        wait_done(cy, to);
        @(negedge clk);
        n_cmp++;
        if (to || res_cnt - r0 !== 2 || done_cnt - d0 !== 1 || exp_res_q.size() !== 0) begin
            n_err++; $display("FAIL midreset_rerun: got res %0d done %0d expected 2 1", res_cnt - r0, done_cnt - d0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_nchunk1();
        test_zero();
        test_wrap();
        test_busy_start();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
